// File: rtl/cast_convert_pipe.sv
// Elastic pipelined integer cast unit (wrap, sign-extend, unsigned/signed saturate, bool reduce).
// Optional saturation/error event counters are enabled by defining CAST_CONVERT_PIPE_STATS_EN.
module cast_convert_pipe #(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 32,
   parameter int IN_SIGNED = 1,
   parameter int STAGES    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_mode,
   input  logic [IN_W-1:0]  i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [OUT_W-1:0] o_data,
   output logic             o_sat,
   output logic             o_err
`ifdef CAST_CONVERT_PIPE_STATS_EN
   ,
   output logic [15:0]      o_sat_cnt,
   output logic [15:0]      o_err_cnt
`endif
);

   // One guard bit above the wider operand keeps every bound comparison overflow-free.
   localparam int MW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
   localparam logic signed [MW-1:0] ONE  = MW'(1);
   localparam logic signed [MW-1:0] UMAX = (ONE <<< OUT_W) - ONE;
   localparam logic signed [MW-1:0] SMAX = (ONE <<< (OUT_W - 1)) - ONE;
   localparam logic signed [MW-1:0] SMIN = -(ONE <<< (OUT_W - 1));

   function automatic logic [OUT_W:0] sat_u(input logic signed [MW-1:0] v);
      logic [OUT_W:0] r;
      if (v[MW-1])
         r = {1'b1, {OUT_W{1'b0}}};
      else if (v > UMAX)
         r = {1'b1, {OUT_W{1'b1}}};
      else
         r = {1'b0, OUT_W'(v)};
      return r;
   endfunction

   function automatic logic [OUT_W:0] sat_s(input logic signed [MW-1:0] v);
      logic [OUT_W:0] r;
      if (v > SMAX)
         r = {1'b1, OUT_W'(SMAX)};
      else if (v < SMIN)
         r = {1'b1, OUT_W'(SMIN)};
      else
         r = {1'b0, OUT_W'(v)};
      return r;
   endfunction

   // Result packed as {err, sat, data}.
   function automatic logic [OUT_W+1:0] cast_op(input logic [2:0] mode, input logic [IN_W-1:0] d);
      logic signed [MW-1:0] ext;
      logic [OUT_W+1:0]     r;
      if (IN_SIGNED != 0)
         ext = MW'($signed(d));
      else
         ext = MW'(d);
      r = '0;
      case (mode)
         3'd0:    r[OUT_W-1:0] = OUT_W'(d);
         3'd1:    r[OUT_W-1:0] = OUT_W'($signed(d));
         3'd2:    r[OUT_W:0]   = sat_u(ext);
         3'd3:    r[OUT_W:0]   = sat_s(ext);
         3'd4:    r[0]         = |d;
         default: r[OUT_W+1]   = 1'b1;
      endcase
      return r;
   endfunction

   logic             s0_valid_p0;
   logic [OUT_W+1:0] s0_res_p0;
   logic             s0_advance;
   logic             out_valid;
   logic [OUT_W+1:0] out_res;

   assign o_ready = !s0_valid_p0 || s0_advance;

   // Stage 0: cast result registered on accept
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s0_valid_p0 <= 1'b0;
         s0_res_p0   <= '0;
      end else if (o_ready) begin
         s0_valid_p0 <= i_valid;
         if (i_valid)
            s0_res_p0 <= cast_op(i_mode, i_data);
      end
   end

   generate
      if (STAGES == 2) begin : g_out_reg
         logic             vld_p1;
         logic [OUT_W+1:0] res_p1;

         assign s0_advance = s0_valid_p0 && (!vld_p1 || i_ready);

         // Stage 1: output register, holds while downstream stalls
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               vld_p1 <= 1'b0;
               res_p1 <= '0;
            end else if (!vld_p1 || i_ready) begin
               vld_p1 <= s0_valid_p0;
               if (s0_valid_p0)
                  res_p1 <= s0_res_p0;
            end
         end

         assign out_valid = vld_p1;
         assign out_res   = res_p1;
      end else begin : g_direct
         assign s0_advance = s0_valid_p0 && i_ready;
         assign out_valid  = s0_valid_p0;
         assign out_res    = s0_res_p0;
      end
   endgenerate

   assign o_valid = out_valid;
   assign o_data  = out_res[OUT_W-1:0];
   assign o_sat   = out_res[OUT_W];
   assign o_err   = out_res[OUT_W+1];

`ifdef CAST_CONVERT_PIPE_STATS_EN
   logic emit;
   assign emit = out_valid && i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sat_cnt <= '0;
         o_err_cnt <= '0;
      end else if (emit) begin
         if (o_sat && (o_sat_cnt != 16'hFFFF))
            o_sat_cnt <= o_sat_cnt + 16'd1;
         if (o_err && (o_err_cnt != 16'hFFFF))
            o_err_cnt <= o_err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cast_convert_pipe.sv
// Directed and scoreboarded bench for cast_convert_pipe (32->8 signed, 2 stages), plus
// a 32->64 instance for sign extension and a single-stage instance for latency.
module tb_cast_convert_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance: IN_W=32, OUT_W=8, signed, 2 stages
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [2:0]  i_mode = '0;
   logic [31:0] i_data = '0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [7:0]  o_data;
   logic        o_sat;
   logic        o_err;
`ifdef CAST_CONVERT_PIPE_STATS_EN
   logic [15:0] o_sat_cnt, o_err_cnt;
   logic [15:0] w_sat_cnt, w_err_cnt, s_sat_cnt, s_err_cnt;
`endif

   // Wide instance: OUT_W=64
   logic        w_valid = 1'b0;
   logic        w_ready;
   logic [2:0]  w_mode = '0;
   logic [31:0] w_data = '0;
   logic        w_ovalid;
   logic [63:0] w_odata;
   logic        w_osat, w_oerr;

   // Single-stage instance
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [2:0]  s_mode = '0;
   logic [31:0] s_data = '0;
   logic        s_ovalid;
   logic [7:0]  s_odata;
   logic        s_osat, s_oerr;

   cast_convert_pipe #(.IN_W(32), .OUT_W(8), .IN_SIGNED(1), .STAGES(2)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
      .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
      .o_sat(o_sat), .o_err(o_err)
`ifdef CAST_CONVERT_PIPE_STATS_EN
      , .o_sat_cnt(o_sat_cnt), .o_err_cnt(o_err_cnt)
`endif
   );

   cast_convert_pipe #(.IN_W(32), .OUT_W(64), .IN_SIGNED(1), .STAGES(2)) u_wide (
      .i_clk(clk), .i_rst(rst), .i_valid(w_valid), .o_ready(w_ready), .i_mode(w_mode),
      .i_data(w_data), .o_valid(w_ovalid), .i_ready(1'b1), .o_data(w_odata),
      .o_sat(w_osat), .o_err(w_oerr)
`ifdef CAST_CONVERT_PIPE_STATS_EN
      , .o_sat_cnt(w_sat_cnt), .o_err_cnt(w_err_cnt)
`endif
   );

   cast_convert_pipe #(.IN_W(32), .OUT_W(8), .IN_SIGNED(1), .STAGES(1)) u_s1 (
      .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready), .i_mode(s_mode),
      .i_data(s_data), .o_valid(s_ovalid), .i_ready(1'b1), .o_data(s_odata),
      .o_sat(s_osat), .o_err(s_oerr)
`ifdef CAST_CONVERT_PIPE_STATS_EN
      , .o_sat_cnt(s_sat_cnt), .o_err_cnt(s_err_cnt)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Independent reference for OUT_W=8, signed 32-bit input: {err, sat, data}
   function automatic logic [9:0] ref_cast(input logic [2:0] m, input logic [31:0] d);
      longint v;
      v = longint'($signed(d));
      case (m)
         3'd0, 3'd1: return {2'b00, d[7:0]};
         3'd2: begin
            if (v < 0)        return {2'b01, 8'h00};
            else if (v > 255) return {2'b01, 8'hFF};
            else              return {2'b00, d[7:0]};
         end
         3'd3: begin
            if (v > 127)       return {2'b01, 8'h7F};
            else if (v < -128) return {2'b01, 8'h80};
            else               return {2'b00, d[7:0]};
         end
         3'd4:    return {2'b00, 7'b0, (d != 0)};
         default: return {2'b10, 8'h00};
      endcase
   endfunction

   // One transaction through the main instance; checks 2-cycle latency and result
   task automatic run_one(input string tag, input logic [2:0] m, input logic [31:0] d,
                          input logic [7:0] ed, input logic es, input logic ee);
      @(negedge clk);
      i_valid = 1'b1; i_mode = m; i_data = d;
      @(posedge clk); #1;
      i_valid = 1'b0;
      check({tag, "_lat1"}, o_valid, 1'b0);
      @(posedge clk); #1;
      check({tag, "_vld"}, o_valid, 1'b1);
      check({tag, "_data"}, o_data, ed);
      check({tag, "_sat"}, o_sat, es);
      check({tag, "_err"}, o_err, ee);
   endtask

   logic [31:0] sdata [100];
   logic [2:0]  smode [100];
   logic [9:0]  q [$];
   logic [9:0]  exp_r;
   int          sent, rcvd, occ;

   initial begin
      // Reset state
      #12;
      check("rst_vld", o_valid, 1'b0);
      check("rst_data", o_data, 8'h00);
      check("rst_sat", o_sat, 1'b0);
      check("rst_err", o_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready", o_ready, 1'b1);

      // Directed vectors
      run_one("ssat_300",  3'd3, 32'd300,        8'h7F, 1'b1, 1'b0);
      run_one("ssat_m200", 3'd3, -32'sd200,      8'h80, 1'b1, 1'b0);
      run_one("ssat_127",  3'd3, 32'd127,        8'h7F, 1'b0, 1'b0);
      run_one("ssat_m128", 3'd3, -32'sd128,      8'h80, 1'b0, 1'b0);
      run_one("usat_m5",   3'd2, -32'sd5,        8'h00, 1'b1, 1'b0);
      run_one("usat_255",  3'd2, 32'd255,        8'hFF, 1'b0, 1'b0);
      run_one("usat_256",  3'd2, 32'd256,        8'hFF, 1'b1, 1'b0);
      run_one("wrap_1a5",  3'd0, 32'h0000_01A5,  8'hA5, 1'b0, 1'b0);
      run_one("sext_trunc",3'd1, 32'hFFFF_FF3C,  8'h3C, 1'b0, 1'b0);
      run_one("bool_nz",   3'd4, 32'h0001_0000,  8'h01, 1'b0, 1'b0);
      run_one("bool_z",    3'd4, 32'h0000_0000,  8'h00, 1'b0, 1'b0);
      run_one("rsvd_6",    3'd6, 32'h1234_5678,  8'h00, 1'b0, 1'b1);

      // Wide sign extension and zero extension
      @(negedge clk);
      w_valid = 1'b1; w_mode = 3'd1; w_data = 32'h8000_0000;
      @(negedge clk);
      w_mode = 3'd0;
      @(negedge clk);
      w_valid = 1'b0;
      check("w64_sext_vld", w_ovalid, 1'b1);
      check("w64_sext", w_odata, 64'hFFFF_FFFF_8000_0000);
      @(posedge clk); #1;
      check("w64_wrap", w_odata, 64'h0000_0000_8000_0000);

      // Single-stage latency
      @(negedge clk);
      s_valid = 1'b1; s_mode = 3'd3; s_data = 32'd300;
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("s1_vld", s_ovalid, 1'b1);
      check("s1_data", {s_oerr, s_osat, s_odata}, {2'b01, 8'h7F});

      // Streaming with random backpressure against the scoreboard
      for (int k = 0; k < 100; k++) begin
         smode[k] = 3'($urandom_range(0, 5));
         sdata[k] = (k % 3 == 0) ? 32'($urandom) : 32'($urandom_range(0, 600)) - 32'd300;
      end
      sent = 0; rcvd = 0;
      for (int cyc = 0; cyc < 2000 && rcvd < 100; cyc++) begin
         @(negedge clk);
         i_ready = 1'($urandom_range(0, 1));
         if (sent < 100) begin
            i_valid = 1'b1; i_mode = smode[sent]; i_data = sdata[sent];
         end else begin
            i_valid = 1'b0;
         end
         #1;
         occ = q.size();
         check("stream_ready", o_ready, !(occ == 2 && !i_ready));
         if (o_valid && i_ready) begin
            if (q.size() == 0) begin
               check("stream_extra", 1'b1, 1'b0);
            end else begin
               exp_r = q.pop_front();
               check("stream_out", {o_err, o_sat, o_data}, exp_r);
            end
            rcvd++;
         end
         if (i_valid && o_ready) begin
            q.push_back(ref_cast(i_mode, i_data));
            sent++;
         end
      end
      check("stream_count", 64'(rcvd), 64'd100);
      check("stream_sent", 64'(sent), 64'd100);

      // Async reset with two transactions in flight
      @(negedge clk);
      i_ready = 1'b0; i_valid = 1'b1; i_mode = 3'd0; i_data = 32'd10;
      @(negedge clk);
      i_data = 32'd20;
      @(negedge clk);
      i_valid = 1'b0;
      check("full_vld", o_valid, 1'b1);
      check("full_ready", o_ready, 1'b0);
      check("full_data", o_data, 8'd10);
      #2 rst = 1'b1;
      #1;
      check("arst_vld", o_valid, 1'b0);
      check("arst_data", o_data, 8'h00);
      @(negedge clk);
      rst = 1'b0; i_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("arst_stale", o_valid, 1'b0);
      end

`ifdef CAST_CONVERT_PIPE_STATS_EN
      check("cnt_rst_sat", o_sat_cnt, 16'd0);
      run_one("st_ssat", 3'd3, 32'd300,   8'h7F, 1'b1, 1'b0);
      run_one("st_ssat2",3'd3, -32'sd200, 8'h80, 1'b1, 1'b0);
      run_one("st_usat", 3'd2, -32'sd5,   8'h00, 1'b1, 1'b0);
      run_one("st_rsvd", 3'd7, 32'd1,     8'h00, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("cnt_sat", o_sat_cnt, 16'd3);
      check("cnt_err", o_err_cnt, 16'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
